// File: rtl/snake_draw_exec.sv
// snake_draw_exec: buffers draw commands, rasterises superpixel/rect fills, forwards two-word aux commands
module snake_draw_exec #(
    parameter int CMD_WIDTH     = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int SPIXEL_PHY    = 20,
    parameter int H_PHY_MAX     = 639,
    parameter int V_PHY_MAX     = 479,
    parameter int FB_ADDR_WIDTH = 19
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CMD_WIDTH-1:0]     cmd_i,
    input  logic                     cmd_vld_i,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr_o,
    output logic [7:0]               fb_data_o,
    output logic                     fb_we_o,
    input  logic                     fb_rdy_i,
    output logic [2*CMD_WIDTH-1:0]   aux_cmd_o,
    output logic                     aux_vld_o,
    input  logic                     aux_rdy_i,
    output logic                     busy_o,
    output logic                     ovf_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [9:0] SP = 10'(SPIXEL_PHY);

    typedef enum logic [2:0] {IDLE, SETUP, FILL, AUX_WAIT, AUX_OUT} state_t;

    logic [CMD_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, rptr_q;
    logic [PW:0]            cnt_q;
    logic                   ovf_q;
    logic                   full, empty, push, pop;
    logic [CMD_WIDTH-1:0]   fifo_out;

    state_t                 state_q, state_d;
    logic [CMD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [7:0]             colour_q, colour_d;
    logic [9:0]             px0_q, px0_d, px1_q, px1_d, py1_q, py1_d, px_q, px_d, py_q, py_d;
    logic [2*CMD_WIDTH-1:0] aux_q, aux_d;

    logic [3:0]               op;
    logic [H_LOGIC_WIDTH-1:0] x0, x1;
    logic [V_LOGIC_WIDTH-1:0] y0, y1;
    logic [7:0]               col;
    logic                     in_range, step, row_end;

    assign full     = cnt_q == (PW+1)'(FIFO_DEPTH);
    assign empty    = cnt_q == '0;
    assign push     = cmd_vld_i & ~full;
    assign fifo_out = mem_q[rptr_q];

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= cmd_i;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (cmd_vld_i && full) ovf_q <= 1'b1;
        end
    end

    // Opcode 0 is a one-cell rect with its colour in a different field
    assign op  = cmd_q[31:28];
    assign x0  = cmd_q[27:23];
    assign y0  = cmd_q[22:18];
    assign x1  = (op == 4'h0) ? x0 : cmd_q[17:13];
    assign y1  = (op == 4'h0) ? y0 : cmd_q[12:8];
    assign col = (op == 4'h0) ? cmd_q[17:10] : cmd_q[7:0];

    // Off-screen pixels are stepped over at one per cycle without a write
    assign in_range = (px_q <= 10'(H_PHY_MAX)) && (py_q <= 10'(V_PHY_MAX));
    assign step     = (state_q == FILL) && (~in_range || fb_rdy_i);
    assign row_end  = px_q == px1_q;

    // Next-state logic for command decode, window setup, scan and aux hand-off
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        cmd_d    = cmd_q;
        colour_d = colour_q;
        px0_d    = px0_q;
        px1_d    = px1_q;
        py1_d    = py1_q;
        px_d     = px_q;
        py_d     = py_q;
        aux_d    = aux_q;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                cmd_d   = fifo_out;
                state_d = (fifo_out[31:28] <= 4'h1) ? SETUP :
                          (fifo_out[31:28] == 4'h9 || fifo_out[31:28] == 4'hA) ? AUX_WAIT : IDLE;
            end
            SETUP: begin
                px0_d    = 10'(x0) * SP;
                px_d     = 10'(x0) * SP;
                px1_d    = 10'(x1) * SP + SP - 10'd1;
                py_d     = 10'(y0) * SP;
                py1_d    = 10'(y1) * SP + SP - 10'd1;
                colour_d = col;
                state_d  = (x1 < x0 || y1 < y0) ? IDLE : FILL;
            end
            FILL: if (step) begin
                px_d    = row_end ? px0_q : px_q + 10'd1;
                py_d    = row_end ? py_q + 10'd1 : py_q;
                state_d = (row_end && py_q == py1_q) ? IDLE : FILL;
            end
            AUX_WAIT: if (!empty) begin
                pop     = 1'b1;
                aux_d   = {cmd_q, fifo_out};
                state_d = AUX_OUT;
            end
            AUX_OUT: state_d = aux_rdy_i ? IDLE : AUX_OUT;
            default: state_d = IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            colour_q <= '0;
            px0_q    <= '0;
            px1_q    <= '0;
            py1_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            aux_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            colour_q <= colour_d;
            px0_q    <= px0_d;
            px1_q    <= px1_d;
            py1_q    <= py1_d;
            px_q     <= px_d;
            py_q     <= py_d;
            aux_q    <= aux_d;
        end
    end

    assign fb_addr_o = FB_ADDR_WIDTH'(py_q) * FB_ADDR_WIDTH'(H_PHY_MAX + 1) + FB_ADDR_WIDTH'(px_q);
    assign fb_data_o = colour_q;
    assign fb_we_o   = (state_q == FILL) && in_range;
    assign aux_cmd_o = aux_q;
    assign aux_vld_o = state_q == AUX_OUT;
    assign busy_o    = (state_q != IDLE) || !empty;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_snake_draw_exec.sv
// tb_snake_draw_exec: directed self-checking bench for the draw-command executor
module tb_snake_draw_exec;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd = '0;
    logic        cmd_vld = 1'b0;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_rdy = 1'b0;
    logic [63:0] aux_cmd;
    logic        aux_vld;
    logic        aux_rdy = 1'b0;
    logic        busy;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [18:0] aq[$];
    logic [7:0]  dq[$];
    int          cq[$];
    int          hs = 0;
    int          stall_err = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] paddr;
    logic [7:0]  pdata;

    snake_draw_exec dut (
        .clk_i(clk), .rst_i(rst), .cmd_i(cmd), .cmd_vld_i(cmd_vld),
        .fb_addr_o(fb_addr), .fb_data_o(fb_data), .fb_we_o(fb_we), .fb_rdy_i(fb_rdy),
        .aux_cmd_o(aux_cmd), .aux_vld_o(aux_vld), .aux_rdy_i(aux_rdy),
        .busy_o(busy), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record accepted writes/handshakes and watch that stalled writes hold still
    always @(negedge clk) begin
        if (fb_we && fb_rdy) begin
            aq.push_back(fb_addr);
            dq.push_back(fb_data);
            cq.push_back(cyc);
        end
        if (aux_vld && aux_rdy) hs++;
        if (!rst && prev_stall && (fb_we !== 1'b1 || fb_addr !== paddr || fb_data !== pdata)) stall_err++;
        prev_stall = fb_we && !fb_rdy && !rst;
        paddr = fb_addr;
        pdata = fb_data;
    end

    function automatic int exp_addr(input int k, input int px0, input int w, input int py0);
        return (py0 + k / w) * 640 + px0 + k % w;
    endfunction

    task automatic push(input logic [31:0] w, output int n);
        @(posedge clk); #1;
        cmd = w;
        cmd_vld = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input int lim, output bit to);
        to = 1'b1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_log();
        aq.delete();
        dq.delete();
        cq.delete();
        hs = 0;
        stall_err = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_fb_we got %0d want 0", fb_we); end
        n_cmp++; if (fb_addr !== 19'd0) begin n_bad++; $display("FAIL reset_fb_addr got %0d want 0", fb_addr); end
        n_cmp++; if (fb_data !== 8'd0) begin n_bad++; $display("FAIL reset_fb_data got %h want 00", fb_data); end
        n_cmp++; if (aux_vld !== 1'b0) begin n_bad++; $display("FAIL reset_aux_vld got %0d want 0", aux_vld); end
        n_cmp++; if (aux_cmd !== 64'd0) begin n_bad++; $display("FAIL reset_aux_cmd got %h want 0", aux_cmd); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0d want 0", busy); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0d want 0", ovf); end
    endtask

    task automatic test_superpixel();
        int n, bad, fc;
        bit to;
        clear_log();
        fb_rdy = 1'b1;
        push({4'h0, 5'd1, 5'd2, 8'h0F, 10'd0}, n);
        wait_idle(2000, to);
        fc = (cq.size() > 0) ? cq[0] : -1;
        n_cmp++; if (to) begin n_bad++; $display("FAIL spx_timeout busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() !== 400) begin n_bad++; $display("FAIL spx_count got %0d want 400", aq.size()); end
        n_cmp++; if (fc !== n + 3) begin n_bad++; $display("FAIL spx_latency got cycle %0d want %0d", fc, n + 3); end
        if (aq.size() == 400) begin
            n_cmp++; if (aq[0] !== 19'd25620) begin n_bad++; $display("FAIL spx_first got %0d want 25620", aq[0]); end
            n_cmp++; if (aq[19] !== 19'd25639) begin n_bad++; $display("FAIL spx_row0_end got %0d want 25639", aq[19]); end
            n_cmp++; if (aq[20] !== 19'd26260) begin n_bad++; $display("FAIL spx_row1_start got %0d want 26260", aq[20]); end
            n_cmp++; if (aq[399] !== 19'd37799) begin n_bad++; $display("FAIL spx_last got %0d want 37799", aq[399]); end
        end
        bad = -1;
        for (int k = 0; k < aq.size(); k++)
            if (bad < 0 && (aq[k] !== 19'(exp_addr(k, 20, 20, 40)) || dq[k] !== 8'h0F)) bad = k;
        n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL spx_seq idx %0d got %0d/%h want %0d/0f", bad, aq[bad], dq[bad], exp_addr(bad, 20, 20, 40)); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL spx_busy_after got %0d want 0", busy); end
    endtask

    task automatic test_backpressure();
        int n, bad, stalls;
        bit to;
        clear_log();
        stalls = 0;
        push({4'h0, 5'd1, 5'd2, 8'h0F, 10'd0}, n);
        to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            fb_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (fb_we && !fb_rdy) stalls++;
            if (busy === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
        fb_rdy = 1'b1;
        n_cmp++; if (to) begin n_bad++; $display("FAIL bp_timeout busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() !== 400) begin n_bad++; $display("FAIL bp_count got %0d want 400", aq.size()); end
        bad = -1;
        for (int k = 0; k < aq.size(); k++)
            if (bad < 0 && (aq[k] !== 19'(exp_addr(k, 20, 20, 40)) || dq[k] !== 8'h0F)) bad = k;
        n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL bp_seq idx %0d got %0d/%h want %0d/0f", bad, aq[bad], dq[bad], exp_addr(bad, 20, 20, 40)); end
        n_cmp++; if (stall_err !== 0) begin n_bad++; $display("FAIL bp_stable got %0d unstable stalls want 0 (stalls seen %0d)", stall_err, stalls); end
    endtask

    task automatic test_rect();
        int n, bad;
        bit to;
        clear_log();
        push({4'h1, 5'd30, 5'd22, 5'd31, 5'd23, 8'hA5}, n);
        wait_idle(4000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL rect_timeout busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() !== 1600) begin n_bad++; $display("FAIL rect_count got %0d want 1600", aq.size()); end
        if (aq.size() == 1600) begin
            n_cmp++; if (aq[0] !== 19'd282200) begin n_bad++; $display("FAIL rect_first got %0d want 282200", aq[0]); end
            n_cmp++; if (aq[1599] !== 19'd307199) begin n_bad++; $display("FAIL rect_last got %0d want 307199", aq[1599]); end
        end
        bad = -1;
        for (int k = 0; k < aq.size(); k++)
            if (bad < 0 && (aq[k] !== 19'(exp_addr(k, 600, 40, 440)) || dq[k] !== 8'hA5)) bad = k;
        n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL rect_seq idx %0d got %0d/%h want %0d/a5", bad, aq[bad], dq[bad], exp_addr(bad, 600, 40, 440)); end
    endtask

    task automatic test_clip();
        int n, bad;
        bit to;
        clear_log();
        push({4'h0, 5'd0, 5'd24, 8'h33, 10'd0}, n);
        wait_idle(1000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL clip_y24_timeout busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() !== 0) begin n_bad++; $display("FAIL clip_y24_writes got %0d want 0", aq.size()); end
        clear_log();
        push({4'h1, 5'd5, 5'd0, 5'd4, 5'd0, 8'h11}, n);
        wait_idle(5, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL clip_x1ltx0_idle busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() !== 0) begin n_bad++; $display("FAIL clip_x1ltx0_writes got %0d want 0", aq.size()); end
        clear_log();
        push({4'h1, 5'd31, 5'd23, 5'd31, 5'd24, 8'h5A}, n);
        wait_idle(2000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL clip_part_timeout busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() !== 400) begin n_bad++; $display("FAIL clip_part_count got %0d want 400", aq.size()); end
        bad = -1;
        for (int k = 0; k < aq.size(); k++)
            if (bad < 0 && (aq[k] !== 19'(exp_addr(k, 620, 20, 460)) || dq[k] !== 8'h5A)) bad = k;
        n_cmp++; if (bad >= 0) begin n_bad++; $display("FAIL clip_part_seq idx %0d got %0d/%h want %0d/5a", bad, aq[bad], dq[bad], exp_addr(bad, 620, 20, 460)); end
    endtask

    task automatic test_aux();
        int n, m, unsteady;
        clear_log();
        unsteady = 0;
        aux_rdy = 1'b0;
        push(32'h9123_4567, n);
        repeat (3) @(posedge clk);
        push(32'hA0BC_DEF0, m);
        @(negedge clk);
        n_cmp++; if (aux_vld !== 1'b0) begin n_bad++; $display("FAIL aux_early got %0d want 0 at M+1", aux_vld); end
        @(negedge clk);
        n_cmp++; if (aux_vld !== 1'b1) begin n_bad++; $display("FAIL aux_vld_m2 got %0d want 1", aux_vld); end
        n_cmp++; if (aux_cmd !== 64'h9123_4567_A0BC_DEF0) begin n_bad++; $display("FAIL aux_cmd got %h want 91234567a0bcdef0", aux_cmd); end
        repeat (5) begin
            @(negedge clk);
            if (aux_vld !== 1'b1 || aux_cmd !== 64'h9123_4567_A0BC_DEF0) unsteady++;
        end
        n_cmp++; if (unsteady !== 0) begin n_bad++; $display("FAIL aux_hold got %0d unsteady cycles want 0", unsteady); end
        @(posedge clk); #1;
        aux_rdy = 1'b1;
        @(posedge clk); #1;
        aux_rdy = 1'b0;
        @(negedge clk);
        n_cmp++; if (hs !== 1) begin n_bad++; $display("FAIL aux_handshakes got %0d want 1", hs); end
        n_cmp++; if (aux_vld !== 1'b0) begin n_bad++; $display("FAIL aux_vld_after got %0d want 0", aux_vld); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL aux_busy_after got %0d want 0", busy); end
    endtask

    task automatic test_unknown();
        int n;
        bit to;
        clear_log();
        aux_rdy = 1'b1;
        push(32'h5000_0000, n);
        wait_idle(5, to);
        aux_rdy = 1'b0;
        n_cmp++; if (to) begin n_bad++; $display("FAIL unk_idle busy still %0d want 0", busy); end
        n_cmp++; if (aq.size() + hs !== 0) begin n_bad++; $display("FAIL unk_effects got %0d writes %0d aux want 0", aq.size(), hs); end
    endtask

    task automatic test_overflow_reset();
        clear_log();
        fb_rdy = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            cmd = {4'h0, 5'd0, 5'd0, 8'(i + 1), 10'd0};
            cmd_vld = 1'b1;
        end
        @(posedge clk); #1;
        cmd_vld = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0d want 1", ovf); end
        n_cmp++; if (dut.cnt_q !== 5'd16) begin n_bad++; $display("FAIL ovf_fifo_count got %0d want 16", dut.cnt_q); end
        n_cmp++; if (fb_we !== 1'b1 || fb_data !== 8'h01 || fb_addr !== 19'd0) begin n_bad++; $display("FAIL ovf_stall got we %0d data %h addr %0d want 1/01/0", fb_we, fb_data, fb_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ovf_busy got %0d want 1", busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %0d want 0", ovf); end
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL rst_fb_we got %0d want 0", fb_we); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0d want 0", busy); end
        n_cmp++; if (fb_addr !== 19'd0 || fb_data !== 8'd0) begin n_bad++; $display("FAIL rst_fb_bus got %0d/%h want 0/00", fb_addr, fb_data); end
        fb_rdy = 1'b1;
        aq.delete();
        repeat (20) @(negedge clk);
        n_cmp++; if (aq.size() !== 0) begin n_bad++; $display("FAIL rst_fifo_lost got %0d writes want 0", aq.size()); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_superpixel();
        test_backpressure();
        test_rect();
        test_clip();
        test_aux();
        test_unknown();
        test_overflow_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
